// File: rtl/xmem_l0_loader.sv
// Streams a contiguous run of words from the activation SRAM into the L0 input buffer.
// A 2-entry skid FIFO absorbs the one-cycle SRAM read latency under L0 backpressure.
module xmem_l0_loader #(
   parameter int bw      = 4,
   parameter int row     = 8,
   parameter int addr_bw = 11
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [addr_bw-1:0]    base_addr,
   input  logic [addr_bw:0]      len,
   output logic                  busy,
   output logic                  done,
   output logic                  sram_cen,
   output logic                  sram_wen,
   output logic [addr_bw-1:0]    sram_a,
   input  logic [bw*row-1:0]     sram_q,
   input  logic                  l0_ready,
   output logic                  l0_wr,
   output logic [bw*row-1:0]     l0_data
);

   localparam int W = bw * row;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state, state_next;
   logic [addr_bw-1:0]   base_q;
   logic [addr_bw:0]     len_q;
   logic [addr_bw:0]     issued;
   logic [addr_bw:0]     sent;
   logic [addr_bw-1:0]   last_a;
   logic [addr_bw-1:0]   next_a;
   logic                 inflight;
   logic [1:0]           fifo_count;
   logic [W-1:0]         fifo_head;
   logic [W-1:0]         fifo_tail;
   logic                 issue;
   logic                 pop;
   logic                 push;
   logic [2:0]           occupancy;

   // A read may only issue if its data is guaranteed a FIFO slot when it returns.
   always_comb begin
      pop        = (fifo_count != 2'd0) && l0_ready;
      push       = inflight;
      occupancy  = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, inflight} + 3'd1;
      next_a     = base_q + issued[addr_bw-1:0];
      issue      = (state == RUN) && (issued < len_q) && (occupancy <= 3'd2);
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (pop && (sent == len_q - 1'b1)) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy     = (state == RUN);
   assign done     = (state == DONE);
   assign sram_cen = ~issue;
   assign sram_wen = 1'b1;
   assign sram_a   = issue ? next_a : last_a;
   assign l0_wr    = pop;
   assign l0_data  = fifo_head;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         base_q   <= '0;
         len_q    <= '0;
         issued   <= '0;
         sent     <= '0;
         last_a   <= '0;
         inflight <= 1'b0;
      end else begin
         state    <= state_next;
         inflight <= issue;
         if (issue) begin
            last_a <= next_a;
         end
         if ((state == IDLE) && start) begin
            base_q <= base_addr;
            len_q  <= len;
            issued <= '0;
            sent   <= '0;
         end else begin
            if (issue) begin
               issued <= issued + 1'b1;
            end
            if (pop) begin
               sent <= sent + 1'b1;
            end
         end
      end
   end

   // The head register feeds l0_data directly; the tail only fills when the head is occupied.
   always_ff @(posedge clk) begin
      if (reset) begin
         fifo_count <= 2'd0;
         fifo_head  <= '0;
         fifo_tail  <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (fifo_count == 2'd0) begin
                  fifo_head <= sram_q;
               end else begin
                  fifo_tail <= sram_q;
               end
               fifo_count <= fifo_count + 2'd1;
            end
            2'b01: begin
               fifo_head  <= fifo_tail;
               fifo_count <= fifo_count - 2'd1;
            end
            2'b11: begin
               if (fifo_count == 2'd1) begin
                  fifo_head <= sram_q;
               end else begin
                  fifo_head <= fifo_tail;
                  fifo_tail <= sram_q;
               end
            end
            default: begin
               fifo_count <= fifo_count;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xmem_l0_loader.sv
// Self-checking bench for xmem_l0_loader: a table of transfers, a mid-run reset sequence and
// randomized transfers, all checked against an SRAM array plus word/address ordering rules.
module tb_xmem_l0_loader;

   localparam int AW = 11;
   localparam int W  = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   len = '0;
   logic          busy;
   logic          done;
   logic          sram_cen;
   logic          sram_wen;
   logic [AW-1:0] sram_a;
   logic [W-1:0]  sram_q = '0;
   logic          l0_ready = 1'b1;
   logic          l0_wr;
   logic [W-1:0]  l0_data;

   logic [W-1:0]  mem [0:2047];
   logic [AW-1:0] last_a = '0;
   int            total = 0;
   int            bad = 0;

   typedef struct {
      logic [AW-1:0] base;
      int            n;
      int            mode;
      int            stall_a;
      int            stall_b;
      int            restart_cyc;
      int            exp_done;
   } vec_t;

   vec_t vecs[$];

   xmem_l0_loader #(.bw(4), .row(8), .addr_bw(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
      .busy(busy), .done(done), .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a),
      .sram_q(sram_q), .l0_ready(l0_ready), .l0_wr(l0_wr), .l0_data(l0_data)
   );

   always #5 clk = ~clk;

   // One-cycle-latency SRAM read port.
   always @(posedge clk) begin
      if (!sram_cen) sram_q <= mem[sram_a];
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Runs one transfer from cycle 0 (start) until done; ready mode 0=always, 1=stall window, 2=random.
   task automatic apply_stimulus(input logic [AW-1:0] b, input int n, input int mode,
                                 input int sa, input int sb, input int rc, output int done_cyc);
      int            cyc;
      int            iss;
      int            snt;
      int            last_wr;
      int            limit;
      bit            done_seen;
      logic          rdy;
      logic [AW-1:0] ea;
      base_addr = b;
      len       = 12'(n);
      start     = 1'b1;
      l0_ready  = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      cyc = 1; iss = 0; snt = 0; last_wr = -1; done_seen = 1'b0; done_cyc = -1;
      limit = 4 * n + 60;
      while (!done_seen && cyc < limit) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = !(cyc >= sa && cyc <= sb);
            default: rdy = ($urandom_range(0, 3) != 0);
         endcase
         l0_ready = rdy;
         start    = (cyc == rc);
         if (cyc == rc) begin
            base_addr = 11'($urandom);
            len       = 12'($urandom_range(1, 50));
         end
         @(negedge clk);
         check_output("busy", 32'(busy), 32'(n > 0 && snt < n));
         check_output("done", 32'(done), 32'(snt == n));
         check_output("wen", 32'(sram_wen), 32'd1);
         if (!sram_cen) begin
            ea = b + 11'(iss);
            check_output("addr", 32'(sram_a), 32'(ea));
            check_output("extra_read", 32'(iss < n), 32'd1);
            last_a = ea;
            iss++;
         end else begin
            check_output("addr_hold", 32'(sram_a), 32'(last_a));
         end
         if (l0_wr) begin
            ea = b + 11'(snt);
            check_output("wr_ready", 32'(rdy), 32'd1);
            check_output("data", l0_data, mem[ea]);
            snt++;
            last_wr = cyc;
         end
         check_output("buffered", 32'((iss - snt) <= 2), 32'd1);
         if (done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start    = 1'b0;
      l0_ready = 1'b1;
      check_output("timeout", 32'(done_seen), 32'd1);
      check_output("reads", 32'(iss), 32'(n));
      check_output("writes", 32'(snt), 32'(n));
      if (n > 0) check_output("done_after_wr", 32'(done_cyc), 32'(last_wr + 1));
   endtask

   initial begin
      int dc;
      int rn;
      int rmode;
      logic [AW-1:0] rb;

      for (int a = 0; a < 2048; a++) mem[a] = 32'(a);

      vecs.push_back('{11'h010, 4, 0, 0, 0, -1, 7});
      vecs.push_back('{11'h100, 8, 1, 4, 9, -1, 17});
      vecs.push_back('{11'h7FE, 4, 0, 0, 0, -1, 7});
      vecs.push_back('{11'h055, 0, 0, 0, 0, -1, 1});
      vecs.push_back('{11'h200, 6, 0, 0, 0, 3, 9});
      vecs.push_back('{11'h7FF, 1, 0, 0, 0, -1, 4});
      vecs.push_back('{11'h300, 20, 2, 0, 0, -1, -1});

      // Reset held with start asserted must leave everything idle.
      reset = 1'b1; start = 1'b1; base_addr = 11'h003; len = 12'd5;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check_output("rst_busy", 32'(busy), 32'd0);
         check_output("rst_done", 32'(done), 32'd0);
         check_output("rst_cen", 32'(sram_cen), 32'd1);
         check_output("rst_wen", 32'(sram_wen), 32'd1);
         check_output("rst_a", 32'(sram_a), 32'd0);
         check_output("rst_wr", 32'(l0_wr), 32'd0);
         check_output("rst_data", l0_data, 32'd0);
      end
      reset = 1'b0; start = 1'b0;
      last_a = '0;

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].base, vecs[i].n, vecs[i].mode, vecs[i].stall_a,
                        vecs[i].stall_b, vecs[i].restart_cyc, dc);
         if (vecs[i].exp_done >= 0) check_output("done_cycle", 32'(dc), 32'(vecs[i].exp_done));
      end

      // Reset during cycle 5 of a 16-word transfer.
      base_addr = 11'h020; len = 12'd16; start = 1'b1; l0_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i < 5; i++) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      last_a = '0;
      check_output("mid_busy", 32'(busy), 32'd0);
      check_output("mid_done", 32'(done), 32'd0);
      check_output("mid_cen", 32'(sram_cen), 32'd1);
      check_output("mid_a", 32'(sram_a), 32'd0);
      check_output("mid_wr", 32'(l0_wr), 32'd0);
      check_output("mid_data", l0_data, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check_output("post_rst_wr", 32'(l0_wr), 32'd0);
         check_output("post_rst_cen", 32'(sram_cen), 32'd1);
      end
      apply_stimulus(11'h040, 2, 0, 0, 0, -1, dc);
      check_output("post_rst_done", 32'(dc), 32'd5);

      for (int a = 0; a < 2048; a++) mem[a] = $urandom;
      for (int i = 0; i < 10; i++) begin
         rb    = 11'($urandom);
         rn    = $urandom_range(0, 40);
         rmode = (i % 2 == 0) ? 0 : 2;
         apply_stimulus(rb, rn, rmode, 0, 0, -1, dc);
         if (rmode == 0) check_output("rand_done_cycle", 32'(dc), 32'((rn == 0) ? 1 : rn + 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
